// File: rtl/ssem_timing_if.sv
// Timing-generator bundle: run/step requests in, dash/dot/beat timing and
// P-pulse sequencer state out. The generator drives through the master modport.
interface ssem_timing_if #(
    parameter int DOT_DIV  = 4,
    parameter int BEAT_DIV = 6,
    parameter int N_STAGES = 4
);
    localparam int DASH_W = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
    localparam int DOT_W  = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

    logic                run;
    logic                step;
    logic [DASH_W-1:0]   dash_cnt;
    logic [DOT_W-1:0]    dot_cnt;
    logic                dot;
    logic                dot_tick;
    logic                beat_tick;
    logic                bo;
    logic [N_STAGES-1:0] ps;
    logic                r_out;
    logic                busy;

    modport master (
        input  run, step,
        output dash_cnt, dot_cnt, dot, dot_tick, beat_tick, bo, ps, r_out, busy
    );

    modport slave (
        output run, step,
        input  dash_cnt, dot_cnt, dot, dot_tick, beat_tick, bo, ps, r_out, busy
    );
endinterface

// File: rtl/ssem_timing_gen.sv
// Master timing generator: dash->dot->beat counters, blackout window and an
// N-stage one-hot P-pulse sequencer with single-step and continuous run.
module ssem_timing_gen #(
    parameter int DOT_DIV  = 4,
    parameter int BEAT_DIV = 6,
    parameter int N_STAGES = 4,
    parameter int BO_DOTS  = 1
) (
    input  logic          clk,
    input  logic          reset,
    ssem_timing_if.master tif
);
    localparam int DASH_W = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
    localparam int DOT_W  = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int STG_W  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [DASH_W-1:0] DASH_LAST = DASH_W'(DOT_DIV - 1);
    localparam logic [DASH_W-1:0] DASH_HALF = DASH_W'(DOT_DIV / 2);
    localparam logic [DOT_W-1:0]  DOT_LAST  = DOT_W'(BEAT_DIV - 1);
    localparam logic [DOT_W-1:0]  BO_FIRST  = DOT_W'(BEAT_DIV - BO_DOTS);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(N_STAGES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEQ  = 1'b1;

    logic [DASH_W-1:0]   dash_q;
    logic [DOT_W-1:0]    dot_q;
    logic                dot_tick;
    logic                beat_tick;

    logic [0:0]          state_q, state_d;
    logic [STG_W-1:0]    stg_q, stg_d;
    logic [N_STAGES-1:0] ps_q, ps_d;
    logic                busy_q, busy_d;
    logic                r_out_q, r_out_d;
    logic                pend_q, pend_d;
    logic                req;
    logic                start_seq;

    assign dot_tick  = (dash_q == DASH_LAST);
    assign beat_tick = dot_tick & (dot_q == DOT_LAST);
    assign req       = tif.run | tif.step | pend_q;

    // Counter stage: dashes roll into dots, dots roll into beats
    always_ff @(posedge clk) begin
        if (reset) begin
            dash_q <= '0;
            dot_q  <= '0;
        end else begin
            dash_q <= dot_tick ? '0 : dash_q + DASH_W'(1);
            if (dot_tick)
                dot_q <= (dot_q == DOT_LAST) ? '0 : dot_q + DOT_W'(1);
        end
    end

    // Sequencer next state; every transition is gated by beat_tick
    always_comb begin
        state_d   = state_q;
        stg_d     = stg_q;
        ps_d      = ps_q;
        busy_d    = busy_q;
        r_out_d   = 1'b0;
        start_seq = 1'b0;
        if (beat_tick) begin
            case (state_q)
                ST_IDLE: start_seq = req;
                ST_SEQ: begin
                    if (stg_q != STG_LAST) begin
                        stg_d = stg_q + STG_W'(1);
                        ps_d  = ps_q << 1;
                    end else begin
                        r_out_d = 1'b1;
                        if (req) begin
                            start_seq = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            ps_d    = '0;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ps_d    = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
        if (start_seq) begin
            state_d = ST_SEQ;
            stg_d   = '0;
            ps_d    = N_STAGES'(1);
            busy_d  = 1'b1;
        end
        // A step consumed by the starting sequence must not also stay pending
        pend_d = start_seq ? 1'b0 : (pend_q | tif.step);
    end

    // Sequencer register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stg_q   <= '0;
            ps_q    <= '0;
            busy_q  <= 1'b0;
            r_out_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            ps_q    <= ps_d;
            busy_q  <= busy_d;
            r_out_q <= r_out_d;
            pend_q  <= pend_d;
        end
    end

    assign tif.dash_cnt  = dash_q;
    assign tif.dot_cnt   = dot_q;
    assign tif.dot       = (dash_q < DASH_HALF);
    assign tif.dot_tick  = dot_tick;
    assign tif.beat_tick = beat_tick;
    assign tif.bo        = (dot_q >= BO_FIRST);
    assign tif.ps        = ps_q;
    assign tif.r_out     = r_out_q;
    assign tif.busy      = busy_q;
endmodule

// File: doc/ssem_timing_gen.md
# ssem_timing_gen

Parametrised master timing generator for the reduced machine. It derives the dot, beat and blackout timing from the dash clock using two chained counters, and drives an N-stage one-hot P-pulse sequencer from those beats. It replaces the separate fixed divide-by-4, divide-by-6, blackout and P-pulse blocks with one block, and adds single-step and continuous run modes. All downstream stores and the control unit use its ticks as clock enables.

## Interface

- `DOT_DIV`, 4: dashes (clk cycles) per dot; must be ≥2.
- `BEAT_DIV`, 6: dots per beat; must be ≥2.
- `N_STAGES`, 4: number of P-pulse stages; must be ≥1.
- `BO_DOTS`, 1: number of blackout dots at the end of each beat; range 1..BEAT_DIV-1.

Ports (widths use `$clog2`, minimum 1):

- `clk`  in  1  dash clock; the single clock for the block.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `run`  in  1  level input; while high, sequences repeat back-to-back.
- `step`  in  1  pulse input; requests exactly one sequence.
- `dash_cnt`  out  clog2(DOT_DIV)  current dash index within the dot.
- `dot_cnt`  out  clog2(BEAT_DIV)  current dot index within the beat.
- `dot`  out  1  dot square wave.
- `dot_tick`  out  1  one-cycle pulse on the last dash of each dot.
- `beat_tick`  out  1  one-cycle pulse on the last dash of each beat.
- `bo`  out  1  blackout level.
- `ps`  out  N_STAGES  one-hot P-pulse stage; all zero when idle.
- `r_out`  out  1  one-cycle pulse marking sequence completion.
- `busy`  out  1  high while a sequence is in progress.

## Operation

- **Cycle numbering:** cycle n is the state after n rising edges with `reset` low. Cycle 0 is the first cycle after reset is released.
- **dash_cnt:** free-running count 0..DOT_DIV-1; wraps to 0.
- **dot_tick:** `dot_tick` = (`dash_cnt` == DOT_DIV-1). Combinational from the counter register.
- **dot:** `dot` = (`dash_cnt` < DOT_DIV/2), using integer division. It is high in the first half of each dot.
- **dot_cnt:** increments only on `dot_tick`; wraps from BEAT_DIV-1 to 0.
- **beat_tick:** `beat_tick` = `dot_tick` & (`dot_cnt` == BEAT_DIV-1).
- **bo:** `bo` = (`dot_cnt` ≥ BEAT_DIV-BO_DOTS). It is high for the last BO_DOTS dots of each beat.
- **Request latch:** `pend` is set by `step` in any cycle. It is cleared at the edge where a sequence starts. A `step` arriving during a sequence is held and serviced at that sequence's end.
- **Sequencer FSM**, states IDLE and SEQ(k) for k = 0..N_STAGES-1. All state changes happen only at edges where `beat_tick` = 1.
  - IDLE → SEQ(0) when `run` \| `step` \| `pend`. The request is sampled in the `beat_tick` cycle itself.
  - SEQ(k) → SEQ(k+1) for k < N_STAGES-1.
  - SEQ(N_STAGES-1): `r_out` is set for exactly the next cycle. Then:
    - → SEQ(0) if `run` \| `step` \| `pend` (back-to-back; `r_out` and `ps[0]` are high together);
    - otherwise → IDLE.
- **Registered outputs:** `ps[k]` = 1 exactly in SEQ(k). `busy` = 1 in any SEQ state. `ps`, `busy` and `r_out` are registers; there are no combinational paths from `run` or `step` to outputs.
- **Run dropped mid-sequence:** the current sequence completes normally, including `r_out`.
- **Reset:** synchronous and dominant, including when simultaneous with `step`. It sets `dash_cnt`=0, `dot_cnt`=0, state IDLE, `pend`=0, `ps`=0, `r_out`=0, `busy`=0.
  - Resulting output values: `dot`=1, `dot_tick`=0, `beat_tick`=0, `bo`=0.
  - Reset mid-sequence aborts the sequence; no `r_out` is produced.

## Timing

- Dot period is DOT_DIV cycles; beat period is DOT_DIV·BEAT_DIV cycles (B); one sequence lasts N_STAGES·B cycles.
- `dot_tick` is high in cycles n with n mod DOT_DIV = DOT_DIV-1.
- `beat_tick` is high in cycles n with n mod B = B-1.
- **Latency:** a request present in `beat_tick` cycle m gives `ps[0]` high in cycles m+1..m+B.
- `ps[k]` holds for exactly B cycles with no gap between stages.
- `r_out` is high for 1 cycle, B cycles after the last stage begins.
- `busy` falls in the same cycle that `r_out` rises, unless the next sequence starts back-to-back.
- The worst-case wait from a request to sequence start is B cycles.

## Test plan

All scenarios use the default parameters (B = 24) unless stated.

1. **Free-running counters.** Reset, then hold `run`=0 and `step`=0 for 100 cycles.
   - `dot_tick` is high at cycles 3, 7, 11, …
   - `beat_tick` is high at cycles 23, 47, 71, 95.
   - `bo` is high in cycles 20–23 and 44–47.
   - `dot` is high in cycles 0–1 and 4–5.
   - `ps`=0, `r_out`=0, `busy`=0 throughout.
2. **Single step.** Pulse `step` in cycle 5.
   - `ps`=0001 in cycles 24–47, 0010 in 48–71, 0100 in 72–95, 1000 in 96–119.
   - `r_out`=1 in cycle 120 only; `busy`=1 in cycles 24–119; `ps`=0 from cycle 120.
3. **Continuous run.** Hold `run` high from cycle 0.
   - `r_out` is high in cycles 120, 216, 312, …
   - `ps`=0001 in cycles 120–143.
   - `busy` stays high from cycle 24 onward.
4. **Request edge cases.**
   - `step` in cycle 23 only: the sequence starts at cycle 24.
   - A second `step` in cycle 50: a back-to-back second sequence starts at cycle 120, with `r_out` and `ps[0]` high together; the second `r_out` is in cycle 216.
5. **Reset mid-sequence.** Apply `step`, then assert `reset` in cycle 60.
   - `ps`=0 and `busy`=0 next cycle; no `r_out`.
   - Counters restart, so `beat_tick` is high 23 cycles after release.
   - `reset` and `step` asserted in the same cycle: no sequence starts.
6. **Non-default parameters.** DOT_DIV=2, BEAT_DIV=3, N_STAGES=2, BO_DOTS=2, with `step` in cycle 0.
   - B=6; `bo` is high in cycles 2–5 of every beat.
   - `ps`=01 in cycles 6–11, `ps`=10 in cycles 12–17.
   - `r_out` is high in cycle 18.
